mips_lsu_avalon: RTL and testbench
==================================

Name: mips_lsu_avalon

Overview:
Parametrised load/store unit between the MIPS core datapath and the Avalon memory-mapped master port. It accepts one memory request at a time: LB/LBU/LH/LHU/LW/LWL/LWR/SB/SH/SW. It performs byte-lane steering, sign/zero extension and LWL/LWR merging, obeys waitrequest, and flags misaligned, illegal or timed-out accesses. It replaces ad-hoc byteenable/waitrequest handling inside the CPU FSM.

Parameters:
ADDR_WIDTH, 32, width of req_addr and Avalon address.
ALIGN_CHECK, 1, 1: misaligned LH/LHU/LW/SH/SW return resp_err without a bus cycle; 0: low address bits are ignored and the aligned word/half is accessed.
TIMEOUT_CYCLES, 0, 0 disables the timeout. N>0: abort with resp_err if waitrequest stays high for N consecutive cycles of one access.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
req_op  in  4  lsu_op_t operation.
req_addr  in  ADDR_WIDTH  byte address.
req_wdata  in  32  store data (rt value).
req_rt_old  in  32  current rt value, merged by LWL/LWR.
resp_valid  out  1  one-cycle completion pulse.
resp_rdata  out  32  load result, ready to write back; 0 for stores and errors.
resp_err  out  1  valid with resp_valid: misaligned, illegal op or timeout.
address  out  ADDR_WIDTH  word-aligned: {req_addr[ADDR_WIDTH-1:2],2'b00}.
read  out  1  Avalon read.
write  out  1  Avalon write.
waitrequest  in  1  Avalon stall.
writedata  out  32  lane-steered store data.
byteenable  out  4  active lanes.
readdata  in  32  valid in the cycle after the read is accepted (fixed latency 1).

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, read=0, write=0, address=0, writedata=0, byteenable=0. The FSM goes to IDLE.
- Reset mid-access: read/write deassert asynchronously and no response is produced.
- Little-endian byte lanes: byte at addr[1:0]=k sits on bits [8k+7:8k].
- FSM states: IDLE, BUS, RDATA, DONE.
- IDLE:
  - On accept, latch op, addr, wdata and rt_old.
  - If the op is illegal, or misaligned with ALIGN_CHECK=1, go to DONE with err=1.
  - Otherwise go to BUS.
- BUS:
  - Assert read or write, with address/byteenable/writedata stable.
  - Hold while waitrequest=1; the timeout counter increments each stalled cycle.
  - When waitrequest=0 the access is accepted: reads go to RDATA, writes go to DONE.
  - On timeout (count==TIMEOUT_CYCLES), drop read/write and go to DONE with err=1.
- RDATA: capture readdata, format the result into resp_rdata, go to DONE.
- DONE: resp_valid=1 for exactly one cycle, then IDLE. Requests are not accepted in DONE.
- Latency from accept to resp_valid: writes 2+W cycles, reads 3+W cycles (W = stall cycles); error without a bus cycle, 1 cycle.
- Byteenable for stores:
  - SB: 1<<k, writedata={4{byte}}.
  - SH: 4'b0011<<k (k in {0,2}), writedata={2{half}}.
  - SW: 4'b1111.
- Byteenable for all reads: 4'b1111.
- Load formatting:
  - LB/LBU: lane k, sign-/zero-extended.
  - LH/LHU: lanes k..k+1, sign-/zero-extended.
  - LW: whole word.
  - LWL: (mem << 8*(3-k)) | (rt_old & ((1<<8*(3-k))-1)).
  - LWR: (mem >> 8k) | (rt_old & ~(32'hFFFFFFFF >> 8k)).
  - LWL and LWR are never misaligned.
- Counter width: $clog2(TIMEOUT_CYCLES+1); reset to 0 at each accept.
- Outputs held steady while waitrequest=1 (Avalon rule).

Decomposition:
- Shared package mips_pkg holds:
  - lsu_op_t: LB=0, LBU=1, LH=2, LHU=3, LW=4, LWL=5, LWR=6, SB=8, SH=9, SW=10; all other values are illegal.
  - lsu_state_t.
  - RESET_VECTOR constant 32'hBFC00000, shared with the CPU.
- One sub-module, mips_lsu_align: purely combinational store lane steering and load extend/merge, tested standalone.

Test Plan:
- SW addr 0x1004, wdata 0xDEADBEEF, waitrequest low -> write=1, address=0x1004, byteenable=4'b1111, writedata=0xDEADBEEF; resp_valid 2 cycles after accept, err=0.
- LB addr 0x1003, readdata 0x80112233 -> resp_rdata=0xFFFFFF80. Same with LBU -> 0x00000080. LH addr 0x1002 -> 0xFFFF8011.
- LWL addr 0x1001, mem 0x44332211, rt_old 0xAABBCCDD -> 0x2211CCDD. LWR addr 0x1001 -> 0xAA443322.
- SH addr 0x2002, wdata 0x0000BEEF, waitrequest high for 3 cycles -> outputs stable throughout, byteenable=4'b1100, writedata=0xBEEFBEEF; resp_valid at cycle 5.
- LW addr 0x1002 with ALIGN_CHECK=1 -> no read asserted, resp_valid next cycle, resp_err=1, resp_rdata=0. Op 4'd7 -> same error response.
- TIMEOUT_CYCLES=4, waitrequest stuck high -> read drops after 4 stalled cycles, resp_err=1. Reset asserted mid-BUS -> read=0 immediately, no resp_valid, req_ready=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: LSU operation encoding, LSU FSM states and the
// reset vector used by the CPU.
package mips_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

    typedef enum logic [3:0] {
        LB  = 4'd0,
        LBU = 4'd1,
        LH  = 4'd2,
        LHU = 4'd3,
        LW  = 4'd4,
        LWL = 4'd5,
        LWR = 4'd6,
        SB  = 4'd8,
        SH  = 4'd9,
        SW  = 4'd10
    } lsu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS   = 2'd1,
        RDATA = 2'd2,
        DONE  = 2'd3
    } lsu_state_t;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        case (op)
            SB, SH, SW: return 1'b1;
            default:    return 1'b0;
        endcase
    endfunction

    // LWL/LWR and byte ops can never be misaligned.
    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] off);
        case (op)
            LH, LHU, SH: return off[0];
            LW, SW:      return |off;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_lsu_align.sv
// Combinational byte-lane steering for stores and extend/merge formatting
// for loads. offset must already be half/word aligned for those ops.
module mips_lsu_align
    import mips_pkg::*;
(
    input  lsu_op_t     op,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  logic [31:0] rt_old,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    output logic [31:0] load_data
);

    logic [4:0]  sh_r;
    logic [4:0]  sh_l;
    logic [31:0] shifted;

    assign sh_r    = {offset, 3'b000};
    assign sh_l    = {~offset, 3'b000};
    assign shifted = rdata >> sh_r;

    always_comb begin
        byteenable = 4'b1111;
        writedata  = 32'h0;
        load_data  = 32'h0;
        case (op)
            LB:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            LBU: load_data = {24'h0, shifted[7:0]};
            LH:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            LHU: load_data = {16'h0, shifted[15:0]};
            LW:  load_data = rdata;
            // Unaligned-word halves: memory bytes overwrite only their lanes of rt.
            LWL: load_data = (rdata << sh_l) | (rt_old & ~(32'hFFFFFFFF << sh_l));
            LWR: load_data = shifted | (rt_old & ~(32'hFFFFFFFF >> sh_r));
            SB: begin
                byteenable = 4'b0001 << offset;
                writedata  = {4{wdata[7:0]}};
            end
            SH: begin
                byteenable = 4'b0011 << offset;
                writedata  = {2{wdata[15:0]}};
            end
            SW: writedata = wdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_lsu_avalon.sv
// Single-outstanding load/store unit bridging the MIPS datapath to an
// Avalon-MM master with waitrequest and fixed read latency of one cycle.
module mips_lsu_avalon
    import mips_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int ALIGN_CHECK    = 1,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [31:0]           req_rt_old,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  read,
    output logic                  write,
    input  logic                  waitrequest,
    output logic [31:0]           writedata,
    output logic [3:0]            byteenable,
    input  logic [31:0]           readdata
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    lsu_state_t            state_q, state_d;
    logic [3:0]            op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rt_q;
    logic [31:0]           rdata_q;
    logic                  err_q;
    logic [CW-1:0]         cnt_q;

    logic        accept;
    logic        bad_req;
    logic        is_store;
    logic        timeout_hit;
    logic [1:0]  offset;
    logic [3:0]  be_al;
    logic [31:0] wd_al;
    logic [31:0] ld_al;

    assign accept   = req_valid && req_ready;
    assign bad_req  = !op_legal(req_op) ||
                      ((ALIGN_CHECK != 0) && op_misaligned(req_op, req_addr[1:0]));
    assign is_store = op_is_store(op_q);
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && waitrequest && (cnt_q == TO_LAST);

    // Without alignment checking the low bits are forced to the aligned half/word.
    always_comb begin
        offset = addr_q[1:0];
        case (op_q)
            LH, LHU, SH: offset = {addr_q[1], 1'b0};
            LW, SW:      offset = 2'b00;
            default:     ;
        endcase
    end

    mips_lsu_align u_align (
        .op         (lsu_op_t'(op_q)),
        .offset     (offset),
        .wdata      (wdata_q),
        .rdata      (readdata),
        .rt_old     (rt_q),
        .byteenable (be_al),
        .writedata  (wd_al),
        .load_data  (ld_al)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = bad_req ? DONE : BUS;
            BUS: begin
                if (!waitrequest)    state_d = is_store ? DONE : RDATA;
                else if (timeout_hit) state_d = DONE;
            end
            RDATA: state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= 4'h0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rt_q    <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= req_op;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rt_q    <= req_rt_old;
                rdata_q <= 32'h0;
                err_q   <= bad_req;
                cnt_q   <= '0;
            end
            if (state_q == BUS && waitrequest) begin
                if (timeout_hit) err_q <= 1'b1;
                else             cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == RDATA) rdata_q <= ld_al;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == DONE);
    assign resp_err   = (state_q == DONE) && err_q;
    assign resp_rdata = rdata_q;
    assign address    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign read       = (state_q == BUS) && !is_store;
    assign write      = (state_q == BUS) && is_store;
    assign byteenable = (state_q == BUS) ? be_al : 4'b0000;
    assign writedata  = write ? wd_al : 32'h0;

endmodule

// File: tb/tb_mips_lsu_avalon.sv
// Directed bench for mips_lsu_avalon (ALIGN_CHECK=1, TIMEOUT_CYCLES=4).
module tb_mips_lsu_avalon;

    localparam logic [31:0] GARB = 32'h5A5A5A5A;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = 4'h0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [31:0] req_rt_old = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic        waitrequest = 1'b0;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata = GARB;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mips_lsu_avalon #(.ADDR_WIDTH(32), .ALIGN_CHECK(1), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rt_old(req_rt_old),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .address(address), .read(read), .write(write), .waitrequest(waitrequest),
        .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the accept.
    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rt);
        chk("req_ready_idle", {31'h0, req_ready}, 32'd1);
        req_op = op; req_addr = a; req_wdata = wd; req_rt_old = rt;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic load(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] rt, input logic [31:0] mem, input logic [31:0] exp);
        issue(op, a, 32'h0, rt);
        chk({tag, "_read"}, {31'h0, read}, 32'd1);
        chk({tag, "_addr"}, address, {a[31:2], 2'b00});
        chk({tag, "_be"}, {28'h0, byteenable}, 32'hF);
        @(negedge clk);
        chk({tag, "_rdata_state"}, {30'h0, read, resp_valid}, 32'd0);
        readdata = mem;
        @(negedge clk);
        readdata = GARB;
        chk({tag, "_valid"}, {30'h0, resp_valid, resp_err}, 32'd2);
        chk({tag, "_result"}, resp_rdata, exp);
        @(negedge clk);
    endtask

    initial begin
        #1;
        chk("rst_ready", {31'h0, req_ready}, 32'd1);
        chk("rst_resp", {30'h0, resp_valid, resp_err}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_rw", {30'h0, read, write}, 32'd0);
        chk("rst_address", address, 32'h0);
        chk("rst_writedata", writedata, 32'h0);
        chk("rst_be", {28'h0, byteenable}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // SW, no stalls: two cycles from accept to response
        issue(4'd10, 32'h1004, 32'hDEADBEEF, 32'h0);
        chk("sw_rw", {30'h0, read, write}, 32'd1);
        chk("sw_addr", address, 32'h1004);
        chk("sw_be", {28'h0, byteenable}, 32'hF);
        chk("sw_wd", writedata, 32'hDEADBEEF);
        chk("sw_no_early_resp", {31'h0, resp_valid}, 32'd0);
        @(negedge clk);
        chk("sw_resp", {30'h0, resp_valid, resp_err}, 32'd2);
        chk("sw_write_dropped", {31'h0, write}, 32'd0);
        @(negedge clk);
        chk("sw_resp_pulse", {30'h0, resp_valid, req_ready}, 32'd1);

        load("lb", 4'd0, 32'h1003, 32'h0, 32'h80112233, 32'hFFFFFF80);
        load("lbu", 4'd1, 32'h1003, 32'h0, 32'h80112233, 32'h00000080);
        load("lh", 4'd2, 32'h1002, 32'h0, 32'h80112233, 32'hFFFF8011);
        load("lhu", 4'd3, 32'h1000, 32'h0, 32'h80112233, 32'h00002233);
        load("lw", 4'd4, 32'h1000, 32'h0, 32'h12345678, 32'h12345678);
        load("lwl", 4'd5, 32'h1001, 32'hAABBCCDD, 32'h44332211, 32'h2211CCDD);
        load("lwr", 4'd6, 32'h1001, 32'hAABBCCDD, 32'h44332211, 32'hAA443322);
        load("lwl3", 4'd5, 32'h1003, 32'hAABBCCDD, 32'h44332211, 32'h44332211);

        // SB lane steering; result data is cleared for stores
        issue(4'd8, 32'h3001, 32'h000000A5, 32'h0);
        chk("sb_be", {28'h0, byteenable}, 32'h2);
        chk("sb_wd", writedata, 32'hA5A5A5A5);
        @(negedge clk);
        chk("sb_resp", {30'h0, resp_valid, resp_err}, 32'd2);
        chk("sb_rdata_zero", resp_rdata, 32'h0);
        @(negedge clk);

        // SH with three stall cycles: outputs hold, response at cycle 5
        waitrequest = 1'b1;
        issue(4'd9, 32'h2002, 32'h0000BEEF, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("sh_write_held", {30'h0, read, write}, 32'd1);
            chk("sh_addr_held", address, 32'h2000);
            chk("sh_be_held", {28'h0, byteenable}, 32'hC);
            chk("sh_wd_held", writedata, 32'hBEEFBEEF);
            chk("sh_no_resp", {31'h0, resp_valid}, 32'd0);
            @(negedge clk);
        end
        chk("sh_write_last", {30'h0, read, write}, 32'd1);
        waitrequest = 1'b0;
        @(negedge clk);
        chk("sh_resp", {30'h0, resp_valid, resp_err}, 32'd2);
        @(negedge clk);

        // misaligned LW: immediate error, no bus cycle, rdata cleared
        load("lw_prev", 4'd4, 32'h1000, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D);
        issue(4'd4, 32'h1002, 32'h0, 32'h0);
        chk("mis_no_bus", {30'h0, read, write}, 32'd0);
        chk("mis_resp", {30'h0, resp_valid, resp_err}, 32'd3);
        chk("mis_rdata", resp_rdata, 32'h0);
        @(negedge clk);
        chk("mis_pulse", {31'h0, resp_valid}, 32'd0);

        // illegal op 7
        issue(4'd7, 32'h1000, 32'h0, 32'h0);
        chk("ill_no_bus", {30'h0, read, write}, 32'd0);
        chk("ill_resp", {30'h0, resp_valid, resp_err}, 32'd3);
        @(negedge clk);

        // misaligned SH
        issue(4'd9, 32'h2001, 32'h0, 32'h0);
        chk("mis_sh_resp", {30'h0, write, resp_err}, 32'd1);
        @(negedge clk);

        // timeout after 4 stalled cycles
        waitrequest = 1'b1;
        issue(4'd4, 32'h1000, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("to_read_held", {30'h0, read, resp_valid}, 32'd2);
            @(negedge clk);
        end
        chk("to_read_dropped", {31'h0, read}, 32'd0);
        chk("to_resp", {30'h0, resp_valid, resp_err}, 32'd3);
        chk("to_rdata", resp_rdata, 32'h0);
        @(negedge clk);

        // asynchronous reset in BUS
        issue(4'd4, 32'h1000, 32'h0, 32'h0);
        chk("rb_read", {31'h0, read}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rb_read_async", {31'h0, read}, 32'd0);
        chk("rb_ready", {31'h0, req_ready}, 32'd1);
        chk("rb_no_resp", {31'h0, resp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        waitrequest = 1'b0;
        @(negedge clk);
        chk("rb_after", {30'h0, resp_valid, read}, 32'd0);
        chk("rb_after_ready", {31'h0, req_ready}, 32'd1);

        // normal operation resumes
        load("lb_after_rst", 4'd0, 32'h1001, 32'h0, 32'h80112233, 32'h00000022);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
